// File: rtl/bt656_gen_pkg.sv
// Shared types, code constants and helpers for the BT.656 test-video generator.
package bt656_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EAV,
        ST_HBLANK,
        ST_SAV,
        ST_ACTIVE
    } state_t;

    typedef enum logic [1:0] {
        PAT_COUNTERS = 2'd0,
        PAT_BARS     = 2'd1,
        PAT_RAMP     = 2'd2,
        PAT_GREY     = 2'd3
    } pattern_t;

    localparam logic [7:0] TRS_8      = 8'hFF;
    localparam logic [9:0] TRS_10     = 10'h3FF;
    localparam logic [7:0] BLANK_C_8  = 8'h80;
    localparam logic [7:0] BLANK_Y_8  = 8'h10;
    localparam logic [9:0] BLANK_C_10 = 10'h200;
    localparam logic [9:0] BLANK_Y_10 = 10'h040;
    localparam logic [7:0] MID_8      = 8'h80;
    localparam logic [9:0] MID_10     = 10'h200;
    localparam logic [7:0] CLIP_LO_8  = 8'h01;
    localparam logic [7:0] CLIP_HI_8  = 8'hFE;
    localparam logic [9:0] CLIP_LO_10 = 10'h004;
    localparam logic [9:0] CLIP_HI_10 = 10'h3FB;

    // 8-bit {Y, Cb, Cr} for bars W,Y,C,G,M,R,B,K
    function automatic logic [23:0] bar_ycc(input logic [2:0] idx);
        logic [23:0] ycc;
        case (idx)
            3'd0:    ycc = 24'hEB_80_80;
            3'd1:    ycc = 24'hD2_10_92;
            3'd2:    ycc = 24'hAA_A6_10;
            3'd3:    ycc = 24'h91_36_22;
            3'd4:    ycc = 24'h6A_CA_DE;
            3'd5:    ycc = 24'h51_5A_F0;
            3'd6:    ycc = 24'h29_F0_6E;
            default: ycc = 24'h10_80_80;
        endcase
        return ycc;
    endfunction

    function automatic logic [7:0] xy_word(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_pattern_src.sv
// Active-video word source: selects Cb/Y/Cr for the latched pattern, clips away
// reserved codes and registers the result (first of the two output stages).
module bt656_pattern_src
    import bt656_gen_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  pattern_t      pattern,
    input  logic [DW-1:0] p,
    input  logic [DW-1:0] l,
    input  logic [DW-1:0] n,
    input  logic [1:0]    phase,
    input  logic [2:0]    bar,
    output logic [DW-1:0] word
);

    localparam logic [DW-1:0] MID     = (DW == 10) ? DW'(MID_10) : DW'(MID_8);
    localparam logic [DW-1:0] CLIP_LO = (DW == 10) ? DW'(CLIP_LO_10) : DW'(CLIP_LO_8);
    localparam logic [DW-1:0] CLIP_HI = (DW == 10) ? DW'(CLIP_HI_10) : DW'(CLIP_HI_8);

    logic [23:0]   ycc;
    logic [DW-1:0] bar_y, bar_cb, bar_cr, raw, clipped;

    always_comb begin
        ycc    = bar_ycc(bar);
        bar_y  = DW'(ycc[23:16]) << (DW - 8);
        bar_cb = DW'(ycc[15:8]) << (DW - 8);
        bar_cr = DW'(ycc[7:0]) << (DW - 8);
        raw    = MID;
        case (pattern)
            PAT_COUNTERS: begin
                case (phase)
                    2'd0:    raw = DW'(8'hA5);
                    2'd1:    raw = p;
                    2'd2:    raw = l;
                    default: raw = n;
                endcase
            end
            PAT_BARS: raw = phase[0] ? bar_y : (phase[1] ? bar_cr : bar_cb);
            PAT_RAMP: raw = phase[0] ? p : MID;
            default:  raw = MID;
        endcase
        if (raw < CLIP_LO) begin
            clipped = CLIP_LO;
        end else if (raw > CLIP_HI) begin
            clipped = CLIP_HI;
        end else begin
            clipped = raw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            word <= '0;
        end else begin
            word <= clipped;
        end
    end

endmodule

// File: rtl/bt656_video_gen.sv
// BT.656 interlaced test-video generator with frame-aligned start/stop.
// Optional DVP-style vsync/href outputs are built when BT656_GEN_DVP_EN is defined.
module bt656_video_gen
    import bt656_gen_pkg::*;
#(
    parameter int DW           = 8,
    parameter int H_ACTIVE     = 640,
    parameter int H_BLANK      = 272,
    parameter int V_LINES      = 525,
    parameter int FIELD0_START = 4,
    parameter int FIELD1_START = 266,
    parameter int ACT0_START   = 21,
    parameter int ACT0_END     = 263,
    parameter int ACT1_START   = 283,
    parameter int ACT1_END     = 525
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en_i,
    input  logic [1:0]    pattern_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic          f_o,
    output logic          v_o,
    output logic          h_o,
    output logic          sav_o,
    output logic          eav_o,
    output logic [15:0]   frame_cnt_o
`ifdef BT656_GEN_DVP_EN
    ,
    output logic          dvp_vsync_o,
    output logic          dvp_href_o
`endif
);

    localparam int ACT_WORDS = 2 * H_ACTIVE;
    localparam int CNT_MAX   = (ACT_WORDS > H_BLANK) ? ACT_WORDS : H_BLANK;
    localparam int CW        = $clog2(CNT_MAX) + 1;
    localparam int BAR_WORDS = H_ACTIVE / 4;
    localparam int BW        = $clog2(BAR_WORDS) + 1;

    localparam logic [CW-1:0] REF_LAST = CW'(3);
    localparam logic [CW-1:0] HB_LAST  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] ACT_LAST = CW'(ACT_WORDS - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_WORDS - 1);
    localparam logic [15:0]   L_LAST   = 16'(V_LINES);
    localparam logic [15:0]   F0S      = 16'(FIELD0_START);
    localparam logic [15:0]   F1S      = 16'(FIELD1_START);
    localparam logic [15:0]   A0S      = 16'(ACT0_START);
    localparam logic [15:0]   A0E      = 16'(ACT0_END);
    localparam logic [15:0]   A1S      = 16'(ACT1_START);
    localparam logic [15:0]   A1E      = 16'(ACT1_END);

    localparam logic [DW-1:0] TRS     = (DW == 10) ? DW'(TRS_10) : DW'(TRS_8);
    localparam logic [DW-1:0] BLANK_C = (DW == 10) ? DW'(BLANK_C_10) : DW'(BLANK_C_8);
    localparam logic [DW-1:0] BLANK_Y = (DW == 10) ? DW'(BLANK_Y_10) : DW'(BLANK_Y_8);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg;
    logic [15:0]   line_reg, frame_reg;
    pattern_t      pat_reg;
    logic [BW-1:0] bar_word_reg;
    logic [2:0]    bar_idx_reg;
    logic          start, line_end, frame_end;

    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        line_end   = 1'b0;
        frame_end  = 1'b0;
        case (state_reg)
            ST_IDLE:   if (en_i) begin
                           state_next = ST_EAV;
                           start      = 1'b1;
                       end
            ST_EAV:    if (cnt_reg == REF_LAST) state_next = ST_HBLANK;
            ST_HBLANK: if (cnt_reg == HB_LAST) state_next = ST_SAV;
            ST_SAV:    if (cnt_reg == REF_LAST) state_next = ST_ACTIVE;
            ST_ACTIVE: if (cnt_reg == ACT_LAST) begin
                           line_end = 1'b1;
                           if (line_reg == L_LAST) begin
                               frame_end  = 1'b1;
                               state_next = en_i ? ST_EAV : ST_IDLE;
                           end else begin
                               state_next = ST_EAV;
                           end
                       end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg      <= '0;
            line_reg     <= '0;
            frame_reg    <= '0;
            pat_reg      <= PAT_COUNTERS;
            bar_word_reg <= '0;
            bar_idx_reg  <= '0;
        end else begin
            if (state_next != state_reg || state_reg == ST_IDLE) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (start) begin
                line_reg <= 16'd1;
            end else if (line_end) begin
                line_reg <= frame_end ? 16'd1 : line_reg + 16'd1;
            end
            // Pattern only changes on a frame boundary
            if (start || (frame_end && en_i)) begin
                pat_reg <= pattern_t'(pattern_i);
            end
            if (frame_end) begin
                frame_reg <= frame_reg + 16'd1;
            end
            if (state_reg != ST_ACTIVE) begin
                bar_word_reg <= '0;
                bar_idx_reg  <= '0;
            end else if (bar_word_reg == BAR_LAST) begin
                bar_word_reg <= '0;
                bar_idx_reg  <= bar_idx_reg + 3'd1;
            end else begin
                bar_word_reg <= bar_word_reg + BW'(1);
            end
        end
    end

    logic          f_line, v_line, busy, h_cur;
    logic [DW-1:0] xy_dw, word;
    logic [CW-1:0] pair;

    assign f_line = (line_reg < F0S) || (line_reg >= F1S);
    assign v_line = !(((line_reg >= A0S) && (line_reg <= A0E)) ||
                      ((line_reg >= A1S) && (line_reg <= A1E)));
    assign busy   = (state_reg != ST_IDLE);
    assign h_cur  = (state_reg == ST_EAV) || (state_reg == ST_HBLANK);
    assign xy_dw  = DW'(xy_word(f_line, v_line, state_reg == ST_EAV)) << (DW - 8);
    assign pair   = (cnt_reg >> 2) + CW'(1);

    always_comb begin
        word = '0;
        case (state_reg)
            ST_EAV, ST_SAV: begin
                if (cnt_reg == '0) begin
                    word = TRS;
                end else if (cnt_reg == REF_LAST) begin
                    word = xy_dw;
                end
            end
            ST_HBLANK, ST_ACTIVE: word = cnt_reg[0] ? BLANK_Y : BLANK_C;
            default:              word = '0;
        endcase
    end

    logic [DW-1:0] pat_word, word_s1;
    logic          valid_s1, f_s1, v_s1, h_s1, sav_s1, eav_s1, act_s1;

    bt656_pattern_src #(.DW(DW)) u_pattern_src (
        .clk     (clk),
        .rstn    (rstn),
        .pattern (pat_reg),
        .p       (DW'(pair)),
        .l       (DW'(line_reg)),
        .n       (DW'(frame_reg)),
        .phase   (cnt_reg[1:0]),
        .bar     (bar_idx_reg),
        .word    (pat_word)
    );

    // Stage 1 aligns with the registered pattern word; stage 2 drives the ports
    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_s1  <= '0;
            valid_s1 <= 1'b0;
            f_s1     <= 1'b0;
            v_s1     <= 1'b0;
            h_s1     <= 1'b0;
            sav_s1   <= 1'b0;
            eav_s1   <= 1'b0;
            act_s1   <= 1'b0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            f_o         <= 1'b0;
            v_o         <= 1'b0;
            h_o         <= 1'b0;
            sav_o       <= 1'b0;
            eav_o       <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            word_s1  <= word;
            valid_s1 <= busy;
            f_s1     <= busy && f_line;
            v_s1     <= busy && v_line;
            h_s1     <= h_cur;
            sav_s1   <= (state_reg == ST_SAV) && (cnt_reg == REF_LAST);
            eav_s1   <= (state_reg == ST_EAV) && (cnt_reg == REF_LAST);
            act_s1   <= (state_reg == ST_ACTIVE) && !v_line;
            data_o      <= act_s1 ? pat_word : word_s1;
            valid_o     <= valid_s1;
            f_o         <= f_s1;
            v_o         <= v_s1;
            h_o         <= h_s1;
            sav_o       <= sav_s1;
            eav_o       <= eav_s1;
            frame_cnt_o <= frame_reg;
        end
    end

`ifdef BT656_GEN_DVP_EN
    logic vsync_s1, href_s1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vsync_s1    <= 1'b0;
            href_s1     <= 1'b0;
            dvp_vsync_o <= 1'b0;
            dvp_href_o  <= 1'b0;
        end else begin
            vsync_s1    <= (state_reg == ST_EAV) && (line_reg == 16'd1);
            href_s1     <= (state_reg == ST_ACTIVE) && !v_line;
            dvp_vsync_o <= vsync_s1;
            dvp_href_o  <= href_s1;
        end
    end
`endif

endmodule

// File: tb/tb_bt656_video_gen.sv
// Directed bench: small 8-bit geometry for timing/flags/patterns/stop/reset,
// plus a default-geometry 10-bit instance for the colour-bar check.
module tb_bt656_video_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, en, en_b;
    logic [1:0]  pat, pat_b;
    logic [7:0]  data;
    logic        valid, f, v, h, sav, eav;
    logic [15:0] fcnt;
    logic [9:0]  data_b;
    logic        valid_b, f_b, v_b, h_b, sav_b, eav_b;
    logic [15:0] fcnt_b;

    int checks = 0;
    int failures = 0;
    int pos = 0;

`ifdef BT656_GEN_DVP_EN
    logic vsync, href, vsync_b, href_b;
    int   href_cnt, vsync_cnt;
    always @(posedge clk) begin
        if (!rstn) begin
            href_cnt  <= 0;
            vsync_cnt <= 0;
        end else begin
            if (href) href_cnt <= href_cnt + 1;
            if (vsync) vsync_cnt <= vsync_cnt + 1;
        end
    end
`endif

    bt656_video_gen #(
        .DW(8), .H_ACTIVE(16), .H_BLANK(8), .V_LINES(16),
        .FIELD0_START(1), .FIELD1_START(9),
        .ACT0_START(3), .ACT0_END(6), .ACT1_START(11), .ACT1_END(14)
    ) u_small (
        .clk         (clk),
        .rstn        (rstn),
        .en_i        (en),
        .pattern_i   (pat),
        .data_o      (data),
        .valid_o     (valid),
        .f_o         (f),
        .v_o         (v),
        .h_o         (h),
        .sav_o       (sav),
        .eav_o       (eav),
        .frame_cnt_o (fcnt)
`ifdef BT656_GEN_DVP_EN
        ,
        .dvp_vsync_o (vsync),
        .dvp_href_o  (href)
`endif
    );

    bt656_video_gen #(.DW(10)) u_big (
        .clk         (clk),
        .rstn        (rstn),
        .en_i        (en_b),
        .pattern_i   (pat_b),
        .data_o      (data_b),
        .valid_o     (valid_b),
        .f_o         (f_b),
        .v_o         (v_b),
        .h_o         (h_b),
        .sav_o       (sav_b),
        .eav_o       (eav_b),
        .frame_cnt_o (fcnt_b)
`ifdef BT656_GEN_DVP_EN
        ,
        .dvp_vsync_o (vsync_b),
        .dvp_href_o  (href_b)
`endif
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Word k of a frame is on data_o just after edge k+2 counted from the start edge
    task automatic seek(input int k);
        repeat (k + 2 - pos) @(posedge clk);
        pos = k + 2;
        #1;
    endtask

    task automatic begin_frame();
        @(posedge clk);
        pos = 0;
    endtask

    function automatic int ws(input int line, input int word);
        return (line - 1) * 48 + word - 1;
    endfunction

    function automatic int wb(input int line, input int word);
        return (line - 1) * 1560 + word - 1;
    endfunction

    initial begin
        rstn = 1'b0; en = 1'b0; en_b = 1'b0; pat = 2'd0; pat_b = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 16'(data), 16'h00);
        check("rst_valid", 16'(valid), 16'h0);
        check("rst_flags", 16'({f, v, h, sav, eav}), 16'h0);
        check("rst_fcnt", fcnt, 16'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_valid", 16'(valid), 16'h0);

        // Frame 1: counters pattern, en dropped during line 5
        pat = 2'd0; en = 1'b1;
        begin_frame();
        seek(-1);           check("start_lat_valid", 16'(valid), 16'h0);
        seek(0);            check("l1_eav_ff", 16'(data), 16'hFF);
        check("l1_valid", 16'(valid), 16'h1);
        seek(1);            check("l1_eav_00", 16'(data), 16'h00);
        seek(3);            check("l1_eav_xy", 16'(data), 16'hB6);
        check("l1_eav_flag", 16'({eav, sav, h}), 16'b101);
        seek(ws(1, 5));     check("hblank_80", 16'(data), 16'h80);
        seek(ws(1, 6));     check("hblank_10", 16'(data), 16'h10);
        seek(ws(1, 17));    check("vblank_act_80", 16'(data), 16'h80);
        seek(ws(1, 18));    check("vblank_act_10", 16'(data), 16'h10);
        seek(ws(3, 16));    check("l3_sav_xy", 16'(data), 16'h80);
        check("l3_sav_flag", 16'({eav, sav, h}), 16'b010);
        seek(ws(4, 17));    check("cnt_cb", 16'(data), 16'hA5);
        check("cnt_v", 16'(v), 16'h0);
        seek(ws(4, 18));    check("cnt_y0_p1", 16'(data), 16'h01);
        seek(ws(4, 19));    check("cnt_cr_l4", 16'(data), 16'h04);
        seek(ws(4, 20));    check("cnt_y1_n0_clip", 16'(data), 16'h01);
        seek(ws(4, 22));    check("cnt_y0_p2", 16'(data), 16'h02);
        seek(ws(4, 46));    check("cnt_y0_p8", 16'(data), 16'h08);
        seek(ws(5, 1));     en = 1'b0;
        seek(ws(9, 16));    check("l9_sav_xy", 16'(data), 16'hEC);
        seek(ws(11, 4));    check("l11_eav_xy", 16'(data), 16'hDA);
        seek(ws(16, 47));   check("fcnt_before", fcnt, 16'd0);
        seek(ws(16, 48));   check("fcnt_after", fcnt, 16'd1);
        check("last_word", 16'(data), 16'h10);
        check("last_valid", 16'(valid), 16'h1);
        seek(768);          check("stop_valid", 16'(valid), 16'h0);
`ifdef BT656_GEN_DVP_EN
        check("dvp_href_words", 16'(href_cnt), 16'd256);
        check("dvp_vsync_words", 16'(vsync_cnt), 16'd4);
`endif
        seek(772);          check("idle_hold", 16'(valid), 16'h0);

        // Frame 2: colour bars, restart, pattern change mid-frame ignored
        pat = 2'd1; en = 1'b1;
        begin_frame();
        seek(-1);           check("restart_lat", 16'(valid), 16'h0);
        seek(0);            check("restart_ff", 16'(data), 16'hFF);
        pat = 2'd2;
        seek(ws(3, 17));    check("bar_w_cb", 16'(data), 16'h80);
        seek(ws(3, 18));    check("bar_w_y", 16'(data), 16'hEB);
        seek(ws(3, 21));    check("bar_y_cb", 16'(data), 16'h10);
        seek(ws(3, 22));    check("bar_y_y", 16'(data), 16'hD2);
        seek(ws(3, 23));    check("bar_y_cr", 16'(data), 16'h92);
        seek(ws(3, 46));    check("bar_k_y", 16'(data), 16'h10);
        seek(767);          check("f2_fcnt", fcnt, 16'd2);
        seek(768);          check("continuous_ff", 16'(data), 16'hFF);
        check("continuous_valid", 16'(valid), 16'h1);

        // Reset during ACTIVE of line 12 in the next frame
        seek(768 + ws(12, 20));
        check("l12_f", 16'({f, v}), 16'b10);
        rstn = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_data", 16'(data), 16'h00);
        check("mid_rst_valid", 16'(valid), 16'h0);
        check("mid_rst_flags", 16'({f, v, h, sav, eav}), 16'h0);
        check("mid_rst_fcnt", fcnt, 16'h0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Frame after reset: luma ramp
        pat = 2'd2; en = 1'b1;
        begin_frame();
        seek(0);            check("post_rst_ff", 16'(data), 16'hFF);
        seek(ws(3, 17));    check("ramp_cb", 16'(data), 16'h80);
        seek(ws(3, 18));    check("ramp_y_p1", 16'(data), 16'h01);
        seek(ws(3, 22));    check("ramp_y_p2", 16'(data), 16'h02);
        en = 1'b0;

        // 10-bit default geometry, colour bars
        pat_b = 2'd1; en_b = 1'b1;
        begin_frame();
        seek(0);            check("b_eav_3ff", 16'(data_b), 16'h3FF);
        seek(3);            check("b_l1_xy", 16'(data_b), 16'h3C4);
        seek(4);            check("b_blank_200", 16'(data_b), 16'h200);
        seek(5);            check("b_blank_040", 16'(data_b), 16'h040);
        seek(wb(21, 281));  check("b_w_cb", 16'(data_b), 16'h200);
        check("b_l21_fv", 16'({f_b, v_b}), 16'b00);
        seek(wb(21, 282));  check("b_w_y0", 16'(data_b), 16'h3AC);
        seek(wb(21, 283));  check("b_w_cr", 16'(data_b), 16'h200);
        seek(wb(21, 284));  check("b_w_y1", 16'(data_b), 16'h3AC);
        seek(wb(21, 438));  check("b_px79_white", 16'(data_b), 16'h3AC);
        seek(wb(21, 441));  check("b_px80_cb", 16'(data_b), 16'h040);
        seek(wb(21, 442));  check("b_px80_y", 16'(data_b), 16'h348);
        seek(wb(21, 443));  check("b_px80_cr", 16'(data_b), 16'h248);
        en_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
